exec_trace_monitor: RTL
=======================

Name: exec_trace_monitor

Overview:
Passive observer that sits beside the processor core. It samples the core's per-cycle observable outputs (pc_out, alu_result and the eight control flags) and buffers each sample as a trace entry in a small FIFO. A downstream consumer (bench, UART dumper) drains the FIFO over a valid/ready handshake. The block also keeps saturating instruction-class counters and detects a halted core (PC stuck).

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
HALT_CYCLES, 4, consecutive cycles with an unchanged PC that declare a halt; >=2
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
enable  input  1  arms capture; sampled in IDLE
pc_out  input  16  core program counter
alu_result  input  16  core ALU result
jump, branch, mem_read, mem_write, alu_src, reg_write, reg_dst, jump_reg  input  1 each  core control flags
tr_valid  output  1  FIFO head entry available
tr_ready  input  1  consumer accepts head
tr_data  output  40  {pc[39:24], alu_result[23:8], flags[7:0]}; flags = {jump_reg,reg_dst,reg_write,alu_src,mem_write,mem_read,branch,jump}
instr_count  output  CNT_W  entries captured (pushed or dropped)
mem_count  output  CNT_W  captures with mem_read|mem_write
ctrl_count  output  CNT_W  captures with jump|branch|jump_reg
drop_count  output  CNT_W  captures lost to a full FIFO
overflow  output  1  sticky; set on the first drop
halted  output  1  high in HALTED state
state_o  output  2  IDLE=0, RUN=1, HALTED=2

Behaviour:
- Reset: FIFO emptied (tr_valid=0, tr_data=0), all counters=0, overflow=0, halted=0, state IDLE, prev_valid=0, stuck counter=0. Reset asserted mid-operation aborts everything in one cycle; a reset in the same cycle as a handshake or capture wins.
- FSM: IDLE -> RUN when enable=1 (the capture starts on the following cycle). RUN -> HALTED when the stuck counter reaches HALT_CYCLES-1 and the current pc equals prev_pc. RUN -> IDLE when enable=0 (counters and FIFO are retained). HALTED is left only by reset.
- Capture: every RUN cycle with enable=1 produces one sample, including the cycle that causes the halt transition. No capture occurs in IDLE or HALTED.
- Halt detect: prev_pc is registered on each capture and prev_valid is set. The stuck counter increments when prev_valid and pc_out==prev_pc; otherwise it clears to 0. The first capture after IDLE never counts as stuck.
- FIFO: circular buffer with a log2(DEPTH)+1-bit count and pointers that wrap modulo DEPTH. tr_data is the head entry, shown combinationally from the registered array. It is valid whenever count>0 and stays stable while tr_valid && !tr_ready.
- Pop occurs when tr_valid && tr_ready.
- Push when full with a pop in the same cycle: both happen, count is unchanged, no drop.
- Push when full with no pop: the sample is discarded, drop_count increments, overflow is set.
- Push and pop in the same cycle when count=1: legal; the count stays 1 and the head becomes the new entry.
- Pop when empty: ignored.
- Counters: updated on each capture in the same cycle. They saturate at all-ones and never wrap. mem_count and ctrl_count increment on a capture even if that capture is dropped.
- Latency: a sample taken at edge N is visible on tr_data/tr_valid after edge N when the FIFO was empty (one cycle). The counters reflect that capture after the same edge.

Decomposition:
- Package corg_trace_pkg holds: the trace entry width (40), the flag bit positions, the state encodings (IDLE/RUN/HALTED), and a saturating-increment function.
- One sub-module: trace_fifo (parameterised DEPTH/WIDTH synchronous FIFO with push, pop, full, empty and count). The FSM, halt detect and counters stay in the top level.

Test Plan:
- Reset then enable=1. Drive pc 0,2,4 with alu_result 0x0011,0x0022,0x0033 and reg_write=1, with tr_ready=1. Required: three entries in order, tr_data[39:24]=0x0000,0x0002,0x0004, instr_count=3, mem_count=0.
- tr_ready=0 for 20 RUN cycles with DEPTH=16. Required: tr_valid stays high, the head is stable, 16 entries are stored, drop_count=4, overflow=1. Then drain: exactly 16 pops in order, then tr_valid=0.
- FIFO full, tr_ready=1 and capture in the same cycle. Required: no drop, count stays 16, the head advances.
- pc held at 0x0040 from cycle k, with HALT_CYCLES=4. Required: halted=1 and state_o=2 after the 4th equal-PC capture (5 captures at 0x0040). No further captures; the counters are frozen.
- Flags mem_read=1, then mem_write=1, then branch=1, then jump_reg=1 on successive cycles. Required: mem_count=2, ctrl_count=2, tr_data[7:0]=0x04,0x08,0x02,0x80.
- Reset asserted mid-stream with 5 entries queued. Required: the next cycle shows tr_valid=0, all counters=0, overflow=0, state_o=0. Saturation check with CNT_W=4: 20 captures give instr_count=15.

Source files
------------

// File: rtl/corg_trace_pkg.sv
// Shared definitions for the execution trace monitor.
//   TRACE_W      : width of one trace entry {pc, alu_result, flags}
//   FLG_*        : bit positions of the core control flags inside the entry
//   state_t      : monitor FSM encoding (IDLE=0, RUN=1, HALTED=2)
//   trace_t      : packed trace entry layout
//   sat_inc()    : increment that sticks at the all-ones value of a w-bit field
package corg_trace_pkg;

  localparam int TRACE_W = 40;

  localparam int FLG_JUMP      = 0;
  localparam int FLG_BRANCH    = 1;
  localparam int FLG_MEM_READ  = 2;
  localparam int FLG_MEM_WRITE = 3;
  localparam int FLG_ALU_SRC   = 4;
  localparam int FLG_REG_WRITE = 5;
  localparam int FLG_REG_DST   = 6;
  localparam int FLG_JUMP_REG  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] alu;
    logic [7:0]  flags;
  } trace_t;

  // v is a w-bit value zero-extended to 32 bits; w must be 1..32.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max;
    max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous circular-buffer FIFO holding trace entries.
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write request and data; accepted when not full, or when full
//                  and a pop happens in the same cycle
//   pop          : read request; ignored while empty
//   dout         : head entry, combinational from the storage array
//   full, empty  : occupancy flags
//   count        : number of stored entries (0..DEPTH)
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic             w_pop, w_push;

  assign full  = (r_cnt == (AW+1)'(DEPTH));
  assign empty = (r_cnt == '0);
  assign count = r_cnt;
  assign dout  = r_mem[r_rd];

  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/exec_trace_monitor.sv
// Passive execution trace monitor beside the processor core.
//   clk, reset         : clock, synchronous active-high reset
//   enable             : arms capture (IDLE->RUN), RUN->IDLE when low
//   pc_out, alu_result : core observables sampled on each capture
//   jump..jump_reg     : core control flags sampled on each capture
//   tr_valid/ready/data: trace FIFO head, valid/ready handshake
//   *_count            : saturating statistics counters
//   overflow           : sticky, set on first dropped capture
//   halted, state_o    : halt indication and FSM state
module exec_trace_monitor
  import corg_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [15:0]        pc_out,
  input  logic [15:0]        alu_result,
  input  logic               jump,
  input  logic               branch,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               alu_src,
  input  logic               reg_write,
  input  logic               reg_dst,
  input  logic               jump_reg,
  output logic               tr_valid,
  input  logic               tr_ready,
  output logic [TRACE_W-1:0] tr_data,
  output logic [CNT_W-1:0]   instr_count,
  output logic [CNT_W-1:0]   mem_count,
  output logic [CNT_W-1:0]   ctrl_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               overflow,
  output logic               halted,
  output logic [1:0]         state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(HALT_CYCLES) + 1;

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_prev_pc;
  logic               r_prev_valid;
  logic [SW-1:0]      r_stuck;
  logic [CNT_W-1:0]   r_instr, r_mem, r_ctrl, r_drop;
  logic               r_ovf;

  logic               w_capture, w_same_pc, w_halt, w_drop;
  logic               w_full, w_empty, w_is_mem, w_is_ctrl;
  logic [7:0]         w_flags;
  trace_t             w_entry;
  logic [TRACE_W-1:0] w_head;
  logic [AW:0]        w_count;

  always_comb begin
    w_flags                = '0;
    w_flags[FLG_JUMP]      = jump;
    w_flags[FLG_BRANCH]    = branch;
    w_flags[FLG_MEM_READ]  = mem_read;
    w_flags[FLG_MEM_WRITE] = mem_write;
    w_flags[FLG_ALU_SRC]   = alu_src;
    w_flags[FLG_REG_WRITE] = reg_write;
    w_flags[FLG_REG_DST]   = reg_dst;
    w_flags[FLG_JUMP_REG]  = jump_reg;
  end

  assign w_entry   = '{pc: pc_out, alu: alu_result, flags: w_flags};
  assign w_is_mem  = w_flags[FLG_MEM_READ] | w_flags[FLG_MEM_WRITE];
  assign w_is_ctrl = w_flags[FLG_JUMP] | w_flags[FLG_BRANCH] | w_flags[FLG_JUMP_REG];

  assign w_capture = (r_state == ST_RUN) && enable;
  assign w_same_pc = r_prev_valid && (pc_out == r_prev_pc);
  assign w_halt    = w_capture && w_same_pc && (r_stuck == SW'(HALT_CYCLES - 1));
  // Full implies non-empty, so tr_ready alone means a pop is freeing a slot.
  assign w_drop    = w_capture && w_full && !tr_ready;

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(TRACE_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_capture),
    .pop   (tr_ready),
    .din   (w_entry),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign tr_valid    = (w_count != '0);
  assign tr_data     = w_empty ? '0 : w_head;
  assign instr_count = r_instr;
  assign mem_count   = r_mem;
  assign ctrl_count  = r_ctrl;
  assign drop_count  = r_drop;
  assign overflow    = r_ovf;
  assign halted      = (r_state == ST_HALTED);
  assign state_o     = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (enable) w_state_nxt = ST_RUN;
      ST_RUN:    if (!enable) w_state_nxt = ST_IDLE;
                 else if (w_halt) w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Halt tracking restarts whenever the monitor sits in IDLE, so the first
  // capture of a new run never matches a stale PC.
  always_ff @(posedge clk) begin
    if (reset || r_state == ST_IDLE) begin
      r_prev_pc    <= '0;
      r_prev_valid <= 1'b0;
      r_stuck      <= '0;
    end else if (w_capture) begin
      r_prev_pc    <= pc_out;
      r_prev_valid <= 1'b1;
      r_stuck      <= w_same_pc ? r_stuck + SW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_mem   <= '0;
      r_ctrl  <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else if (w_capture) begin
      r_instr <= CNT_W'(sat_inc(32'(r_instr), CNT_W));
      if (w_is_mem)  r_mem  <= CNT_W'(sat_inc(32'(r_mem), CNT_W));
      if (w_is_ctrl) r_ctrl <= CNT_W'(sat_inc(32'(r_ctrl), CNT_W));
      if (w_drop) begin
        r_drop <= CNT_W'(sat_inc(32'(r_drop), CNT_W));
        r_ovf  <= 1'b1;
      end
    end
  end

endmodule
